// File: rtl/alu_operand_stage.sv
// alu_operand_stage: single-entry ID/EX register in front of the ALU.
// Captures decoded operands, immediate, ALU control and destination index from
// decode. It resolves EX/MEM and MEM/WB forwarding on the held source indices
// and drives the ALU operands d1/d2 plus control. Both sides use valid/ready,
// and the stage supports stall and flush.
//
// Optional feature macro: OPSTAGE_FWD_EN
//   defined   : operand forwarding plus hold refresh during stalls
//   undefined : operands come straight from the held register file values;
//               the exmem_*/memwb_* inputs are unused
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      decode-side handshake (in_ready is combinational)
//   rs1_data, rs2_data, imm  operand sources from decode
//   rs1_addr, rs2_addr       source indices used for forwarding
//   rd_addr                  destination index carried downstream
//   alu_src                  1: d2 = imm, 0: d2 = rs2 value
//   alu_ctrl                 ALU operation code
//   flush                    kill the held instruction
//   exmem_*, memwb_*         forwarding sources (write enable, index, value)
//   out_valid / out_ready    ALU-side handshake
//   d1, d2, control, rd_out  ALU operands, control and destination
//   rs2_val                  forwarded rs2 value (store data), ignores alu_src
module alu_operand_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CTRL_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [XLEN-1:0]       imm,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  alu_src,
    input  logic [CTRL_W-1:0]     alu_ctrl,
    input  logic                  flush,
    input  logic                  exmem_wen,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_wen,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_result,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [XLEN-1:0]       d1,
    output logic [XLEN-1:0]       d2,
    output logic [CTRL_W-1:0]     control,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [XLEN-1:0]       rs2_val
);

    logic                  valid_q;
    logic [XLEN-1:0]       rs1_data_q;
    logic [XLEN-1:0]       rs2_data_q;
    logic [XLEN-1:0]       imm_q;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  alu_src_q;
    logic [CTRL_W-1:0]     ctrl_q;
    logic [XLEN-1:0]       fwd1;
    logic [XLEN-1:0]       fwd2;
    logic                  take;

    // Accept when not flushing and the entry is empty or leaving this cycle.
    assign in_ready = !flush && (!valid_q || out_ready);
    assign take     = in_valid && in_ready;

`ifdef OPSTAGE_FWD_EN
    // EX/MEM wins over MEM/WB; x0 is never forwarded; an empty entry ignores forwarding.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [REG_ADDR_W-1:0] idx,
                                                input logic [XLEN-1:0]       held);
        logic [XLEN-1:0] v;
        v = held;
        if (valid_q && exmem_wen && (exmem_rd != '0) && (exmem_rd == idx))
            v = exmem_result;
        else if (valid_q && memwb_wen && (memwb_rd != '0) && (memwb_rd == idx))
            v = memwb_result;
        return v;
    endfunction

    always_comb begin
        fwd1 = fwd_sel(rs1_q, rs1_data_q);
        fwd2 = fwd_sel(rs2_q, rs2_data_q);
    end
`else
    always_comb begin
        fwd1 = rs1_data_q;
        fwd2 = rs2_data_q;
    end

    // Forwarding sources and held indices only matter when forwarding is built in.
    logic unused_fwd;
    assign unused_fwd = ^{exmem_wen, exmem_rd, exmem_result,
                          memwb_wen, memwb_rd, memwb_result, rs1_q, rs2_q};
`endif

    // Entry register: rst > flush > capture > drain / hold refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_src_q  <= 1'b0;
            ctrl_q     <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (take) begin
            valid_q    <= 1'b1;
            rs1_data_q <= rs1_data;
            rs2_data_q <= rs2_data;
            imm_q      <= imm;
            rs1_q      <= rs1_addr;
            rs2_q      <= rs2_addr;
            rd_q       <= rd_addr;
            alu_src_q  <= alu_src;
            ctrl_q     <= alu_ctrl;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
`ifdef OPSTAGE_FWD_EN
        // Latch forwarded values while stalled so they outlive their producer.
        else if (valid_q) begin
            rs1_data_q <= fwd1;
            rs2_data_q <= fwd2;
        end
`endif
    end

    assign out_valid = valid_q;
    assign d1        = fwd1;
    assign d2        = alu_src_q ? imm_q : fwd2;
    assign rs2_val   = fwd2;
    assign control   = ctrl_q;
    assign rd_out    = rd_q;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Single-entry ID/EX pipeline register sitting directly upstream of the ALU.
- Captures decoded operands, immediate, ALU control and destination register from decode.
- Applies EX/MEM and MEM/WB operand forwarding, then drives the ALU inputs d1, d2 and control.
- Uses a valid/ready handshake on both sides, with stall and flush support.

Parameters:
- XLEN, 32, data width of operands and results.
- REG_ADDR_W, 5, register index width.
- CTRL_W, 4, ALU control width (matches ALU control port).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- rs1_data  input  XLEN  register file read port 1.
- rs2_data  input  XLEN  register file read port 2.
- imm  input  XLEN  sign-extended immediate.
- rs1_addr  input  REG_ADDR_W  source register 1 index.
- rs2_addr  input  REG_ADDR_W  source register 2 index.
- rd_addr  input  REG_ADDR_W  destination register index.
- alu_src  input  1  1 selects imm as d2; 0 selects rs2.
- alu_ctrl  input  CTRL_W  ALU operation code.
- flush  input  1  kill the held instruction (branch or jump redirect).
- exmem_wen  input  1  EX/MEM stage writes a register.
- exmem_rd  input  REG_ADDR_W  EX/MEM destination.
- exmem_result  input  XLEN  EX/MEM result value.
- memwb_wen  input  1  MEM/WB stage writes a register.
- memwb_rd  input  REG_ADDR_W  MEM/WB destination.
- memwb_result  input  XLEN  MEM/WB writeback value.
- out_ready  input  1  ALU/EX stage consumes this cycle.
- out_valid  output  1  d1, d2 and control are valid.
- d1  output  XLEN  ALU operand 1.
- d2  output  XLEN  ALU operand 2.
- control  output  CTRL_W  ALU control.
- rd_out  output  REG_ADDR_W  destination index forwarded downstream.
- rs2_val  output  XLEN  forwarded rs2 value (store data), independent of alu_src.

Behaviour:
- Reset (rst=1 at edge):
  - out_valid=0; every stored field is cleared to 0.
  - Hence d1=0, d2=0, control=4'b0000, rd_out=0, rs2_val=0 (forwarding inputs are ignored while the entry is empty).
  - A reset mid-hold drops the instruction.
- in_ready:
  - in_ready = !flush && (!out_valid || out_ready).
  - Purely combinational; no combinational path from in_valid to in_ready.
- Capture:
  - When in_valid && in_ready at an edge, register all input fields; out_valid=1 next cycle.
  - Latency is one cycle. Back-to-back issue is possible at full throughput while out_ready=1.
- Drain: when out_valid && out_ready && !(in_valid && in_ready), out_valid goes to 0 next cycle.
- Flush:
  - When flush=1 and rst=0, out_valid goes to 0 next cycle.
  - in_ready is 0 that cycle, so an incoming instruction is not taken and upstream holds it.
  - flush with out_valid=0 has no effect.
- Forwarding (combinational on stored rs1/rs2 index):
  - Source is exmem_result if exmem_wen && exmem_rd!=0 && exmem_rd==rsX_q.
  - Else memwb_result if memwb_wen && memwb_rd!=0 && memwb_rd==rsX_q.
  - Else the stored rsX_data_q.
  - EX/MEM has priority over MEM/WB. Index 0 is never forwarded.
- Outputs:
  - d1 = fwd1.
  - d2 = alu_src_q ? imm_q : fwd2.
  - rs2_val = fwd2.
  - control = alu_ctrl_q; rd_out = rd_q.
- Hold refresh:
  - Each edge where out_valid && !out_ready && !flush, write rs1_data_q<=fwd1 and rs2_data_q<=fwd2.
  - A forwarded value therefore persists after its producer retires during a stall.
- Precedence per edge: rst > flush > capture > hold refresh.
- Arithmetic: none; all values are passed through at XLEN with no width changes.

Optional Feature:
- OPSTAGE_FWD_EN
  - Defined: forwarding and hold refresh are implemented as above.
  - Undefined: d1=rs1_data_q, d2=alu_src_q?imm_q:rs2_data_q, rs2_val=rs2_data_q. The exmem_*/memwb_* inputs are unused, and hazards are resolved elsewhere by stalling.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with in_valid=1 and rs1_data=32'h10101010.
  - Response: out_valid=0, d1=0, d2=0, control=0 throughout; in_ready=1 after release.
- Basic issue:
  - Stimulus: rs1_data=32'h10101010, rs2_data=32'h01010101, alu_src=0, alu_ctrl=4'b0010, no forwarding.
  - Response: next cycle out_valid=1, d1=32'h10101010, d2=32'h01010101, control=4'b0010.
  - Follow-up: alu_src=1 with imm=32'hFFFFFFF0 gives d2=32'hFFFFFFF0, rs2_val=32'h01010101.
- Forward priority:
  - Stimulus: rs1_addr=5, exmem_rd=5/wen=1/result=32'hAAAA0000, memwb_rd=5/wen=1/result=32'hBBBB0000.
  - Response: d1=32'hAAAA0000.
  - Follow-up: with exmem_wen=0, d1=32'hBBBB0000. With rs1_addr=0 and both rd=0, d1=stored rs1_data.
- Stall refresh:
  - Stimulus: out_ready=0 for 3 cycles; memwb forwards 32'h12345678 to rs2 in cycle 1 only.
  - Response: rs2_val stays 32'h12345678 in cycles 2-3; in_ready=0 while stalled; out_ready=1 then drains.
- Flush versus issue:
  - Stimulus: flush=1 with in_valid=1 while out_valid=1.
  - Response: in_ready=0, out_valid=0 next cycle, new instruction captured on the following cycle with flush=0.
- Back-to-back:
  - Stimulus: 16 instructions with alu_ctrl stepping 4'b0000..4'b1111, out_ready=1.
  - Response: 16 consecutive out_valid cycles, control matching in order, no bubbles.
